// File: rtl/nios_system_keycode_bank.sv
// Avalon-MM bank of keycode channel registers with a change-event FIFO and a level interrupt.
// Each channel write strobes its channel; a write that changes the stored value queues an event.
module nios_system_keycode_bank #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic [NUM_CH-1:0]        ch_strobe,
  output logic                     irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 3;
  localparam logic [3:0] ADDR_STATUS = 4'd8;
  localparam logic [3:0] ADDR_EVENT  = 4'd9;
  localparam logic [3:0] ADDR_CTRL   = 4'd10;

  logic              wr_en, rd_en, ctrl_wr;
  logic [NUM_CH-1:0] ch_sel;
  logic [DATA_W-1:0] ch_q [NUM_CH];
  logic [DATA_W-1:0] new_data;
  logic              push_req, do_push, do_pop, flush;
  logic [2:0]        push_ch;
  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              empty, full, ovf, ie;
  logic [31:0]       rd_data;
  logic              unused_wdata;

  // A simultaneous read and write is treated as a write only.
  assign wr_en    = chipselect & ~write_n;
  assign rd_en    = chipselect & ~read_n & write_n;
  assign ctrl_wr  = wr_en && (address == ADDR_CTRL);
  assign flush    = ctrl_wr & writedata[3];
  assign new_data = writedata[DATA_W-1:0];
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign head     = fifo_mem[rd_ptr];
  assign do_push  = push_req & ~full;
  assign do_pop   = rd_en && (address == ADDR_EVENT) && !empty;
  assign unused_wdata = &{1'b0, writedata};

  always_comb begin
    ch_sel   = '0;
    push_req = 1'b0;
    push_ch  = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = (address == 4'(i));
      if (wr_en && ch_sel[i] && (ch_q[i] != new_data)) begin
        push_req = 1'b1;
        push_ch  = 3'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = ch_q[g];
  end

  // CLR_ALL zeroes every channel silently: no strobe and no event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      ch_strobe <= '0;
    end else begin
      ch_strobe <= {NUM_CH{wr_en}} & ch_sel;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && ch_sel[i]) ch_q[i] <= new_data;
        else if (ctrl_wr && writedata[1]) ch_q[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= {push_ch, new_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  // A dropped push sets OVF even if the same access asks to clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (push_req && full) ovf <= 1'b1;
      else if (ctrl_wr && writedata[2]) ovf <= 1'b0;
      if (ctrl_wr) ie <= writedata[0];
      irq <= ie & (~empty | ovf);
    end
  end

  always_comb begin
    rd_data = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) rd_data = 32'(ch_q[i]);
    end
    if (address == ADDR_STATUS)
      rd_data = {17'd0, 7'(count), 5'd0, ovf, full, empty};
    else if (address == ADDR_EVENT && !empty)
      rd_data = {1'b1, head[EW-1:DATA_W], 28'(head[DATA_W-1:0])};
    else if (address == ADDR_CTRL)
      rd_data = {31'd0, ie};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= 32'd0;
    else if (rd_en) readdata <= rd_data;
  end

endmodule

// File: tb/tb_nios_system_keycode_bank.sv
// Randomized and directed checking of the keycode bank against a queue-based reference model.
// Bus operations start and end on a falling clock edge; outputs are sampled there.
module tb_nios_system_keycode_bank;

  localparam int DATA_W     = 16;
  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [3:0]               address;
  logic                     chipselect, write_n, read_n;
  logic [31:0]              writedata, readdata;
  logic [NUM_CH*DATA_W-1:0] out_port;
  logic [NUM_CH-1:0]        ch_strobe;
  logic                     irq;

  int vectors    = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] m_ch [NUM_CH];
  logic [31:0]       m_q [$];
  logic              m_ovf, m_ie;
  logic [31:0]       m_rdata;
  logic [31:0]       rd, saved;

  nios_system_keycode_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .ch_strobe(ch_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) m_ch[i] = '0;
    m_q.delete();
    m_ovf   = 1'b0;
    m_ie    = 1'b0;
    m_rdata = 32'd0;
  endtask

  function automatic logic [63:0] modelOutPort();
    logic [63:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = m_ch[i];
    return v;
  endfunction

  function automatic logic [31:0] modelStatus();
    logic e = (m_q.size() == 0);
    logic f = (m_q.size() == FIFO_DEPTH);
    return {17'd0, 7'(m_q.size()), 5'd0, m_ovf, f, e};
  endfunction

  task automatic modelWrite(input logic [3:0] a, input logic [31:0] d, output logic [NUM_CH-1:0] strobe);
    int idx = int'(a);
    logic [DATA_W-1:0] nd = d[DATA_W-1:0];
    strobe = '0;
    if (idx < NUM_CH) begin
      strobe = NUM_CH'(1) << idx;
      if (nd != m_ch[idx]) begin
        if (m_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
        else m_q.push_back(32'h8000_0000 | (32'(idx) << 28) | 32'(nd));
      end
      m_ch[idx] = nd;
    end else if (idx == 10) begin
      m_ie = d[0];
      if (d[1]) for (int i = 0; i < NUM_CH; i++) m_ch[i] = '0;
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_q.delete();
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    int idx = int'(a);
    if (idx < NUM_CH) return 32'(m_ch[idx]);
    if (idx == 8)  return modelStatus();
    if (idx == 9)  return (m_q.size() != 0) ? m_q.pop_front() : 32'd0;
    if (idx == 10) return {31'd0, m_ie};
    return 32'd0;
  endfunction

  // One bus cycle; irq seen afterwards reflects the state from before this access.
  task automatic applyStimulus(input logic cs, input logic wr, input logic rq,
                               input logic [3:0] a, input logic [31:0] d, output logic [31:0] rdat);
    logic              exp_irq;
    logic [NUM_CH-1:0] exp_strobe;
    exp_irq    = m_ie & ((m_q.size() != 0) | m_ovf);
    exp_strobe = '0;
    chipselect = cs; write_n = ~wr; read_n = ~rq; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    if (cs && wr) modelWrite(a, d, exp_strobe);
    else if (cs && rq) m_rdata = modelRead(a);
    checkOutput("ch_strobe", 64'(ch_strobe), 64'(exp_strobe));
    checkOutput("readdata",  64'(readdata),  64'(m_rdata));
    checkOutput("irq",       64'(irq),       64'(exp_irq));
    checkOutput("out_port",  64'(out_port),  modelOutPort());
    rdat = readdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] x;
    applyStimulus(1'b1, 1'b1, 1'b0, a, d, x);
  endtask

  task automatic rdReg(input logic [3:0] a, output logic [31:0] v);
    applyStimulus(1'b1, 1'b0, 1'b1, a, 32'd0, v);
  endtask

  task automatic idle();
    logic [31:0] x;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, x);
  endtask

  // Reset lands in the middle of a channel write that must not take effect.
  task automatic doReset();
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = 4'd0; writedata = 32'hABCD;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_readdata",  64'(readdata),  64'd0);
    checkOutput("rst_out_port",  64'(out_port),  64'd0);
    checkOutput("rst_ch_strobe", 64'(ch_strobe), 64'd0);
    checkOutput("rst_irq",       64'(irq),       64'd0);
    chipselect = 1'b0; write_n = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = '0; writedata = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("init_readdata", 64'(readdata), 64'd0);
    checkOutput("init_out_port", 64'(out_port), 64'd0);
    checkOutput("init_irq",      64'(irq),      64'd0);
    reset = 1'b0;

    // Channel write then EVENT pop; first access right after reset release.
    wr(4'd1, 32'h0000_001C);
    idle();
    rdReg(4'd9, rd);  checkOutput("ev_ch1", 64'(rd), 64'h9000_001C);
    rdReg(4'd8, rd);  checkOutput("status_empty", 64'(rd), 64'h0000_0001);

    // Repeated identical value queues a single event.
    wr(4'd0, 32'h0000_0004);
    wr(4'd0, 32'h0000_0004);
    rdReg(4'd8, rd);  checkOutput("status_one", 64'(rd), 64'h0000_0100);
    rdReg(4'd9, rd);  checkOutput("ev_ch0", 64'(rd), 64'h8000_0004);

    // Nine distinct writes overflow an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) wr(4'd0, 32'(i) | 32'hFFFF_0000);
    rdReg(4'd8, rd);  checkOutput("status_ovf", 64'(rd), 64'h0000_0806);
    for (int i = 1; i <= 8; i++) begin
      rdReg(4'd9, rd); checkOutput("ev_order", 64'(rd), 64'h8000_0000 | 64'(i));
    end
    rdReg(4'd9, rd);  checkOutput("ev_drained", 64'(rd), 64'd0);
    wr(4'd10, 32'h4);
    rdReg(4'd8, rd);  checkOutput("status_ovfclr", 64'(rd), 64'h0000_0001);

    // Interrupt on pending event and on overflow.
    wr(4'd10, 32'h1);
    wr(4'd3, 32'h55);
    idle();           checkOutput("irq_event", 64'(irq), 64'd1);
    rdReg(4'd9, rd);
    idle();           checkOutput("irq_popped", 64'(irq), 64'd0);
    for (int i = 0; i < 9; i++) wr(4'd2, 32'h10 + 32'(i));
    for (int i = 0; i < 8; i++) rdReg(4'd9, rd);
    idle();           checkOutput("irq_ovf_held", 64'(irq), 64'd1);
    wr(4'd10, 32'h5);
    idle();           checkOutput("irq_ovf_clr", 64'(irq), 64'd0);

    // CLR_ALL zeroes channels without strobes or events.
    wr(4'd2, 32'h00FF);
    rdReg(4'd8, saved);
    wr(4'd10, 32'h2);
    checkOutput("clr_out_port", 64'(out_port), 64'd0);
    rdReg(4'd8, rd);  checkOutput("clr_count", 64'(rd), 64'(saved));

    // Reset with three events queued.
    wr(4'd1, 32'h1); wr(4'd1, 32'h2); wr(4'd1, 32'h3);
    doReset();
    rdReg(4'd8, rd);  checkOutput("rst_status", 64'(rd), 64'h0000_0001);

    // Random traffic against the model, including dual-strobe and deselected cycles.
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  a;
      logic [31:0] d;
      int          kind = $urandom_range(0, 9);
      int          asel = $urandom_range(0, 9);
      if (asel < 5)       a = 4'($urandom_range(0, NUM_CH - 1));
      else if (asel == 5) a = 4'd8;
      else if (asel < 8)  a = 4'd9;
      else if (asel == 8) a = 4'd10;
      else                a = 4'($urandom_range(0, 15));
      if (a == 4'd10)
        d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 1));
      else
        d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 5));
      if (kind < 4)       applyStimulus(1'b1, 1'b1, 1'b0, a, d, rd);
      else if (kind < 8)  applyStimulus(1'b1, 1'b0, 1'b1, a, d, rd);
      else if (kind == 8) applyStimulus(1'b1, 1'b1, 1'b1, a, d, rd);
      else                applyStimulus(1'b0, $urandom_range(0, 1) == 1, 1'b1, a, d, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_system_keycode_bank.md
NIOS_SYSTEM_KEYCODE_BANK -- requirements
Module: nios_system_keycode_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DATA_W, default 16: bits per keycode channel; legal range 1..28.
REQ-003 Parameter NUM_CH, default 4: number of keycode channels; legal range 1..8.
REQ-004 Parameter FIFO_DEPTH, default 8: event FIFO entries; must be a power of 2 in 2..64.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 address  in  4  Avalon-MM word address.
REQ-008 chipselect  in  1  slave select.
REQ-009 write_n  in  1  active-low write strobe.
REQ-010 read_n  in  1  active-low read strobe.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  read data; read latency 1.
REQ-013 out_port  out  NUM_CH*DATA_W  channel registers concatenated; channel 0 in the LSBs.
REQ-014 ch_strobe  out  NUM_CH  one-cycle pulse per channel on a channel write.
REQ-015 irq  out  1  level interrupt.

Function
REQ-016 A write SHALL be chipselect=1 and write_n=0; a read SHALL be chipselect=1, read_n=0 and write_n=1; when both strobes are asserted the write wins and the read is ignored.
REQ-017 Address map SHALL be:
- 0..NUM_CH-1: CH[n], read/write.
- 8: STATUS, read-only.
- 9: EVENT, read pops.
- 10: CONTROL, read/write.
- All other addresses: reads return 0 and writes are ignored.
REQ-018 A write to CH[n] SHALL load writedata[DATA_W-1:0] into channel n, drive ch_strobe[n]=1 on the next cycle only, and push event {ch=n, data=new} when the new value differs from the old value.
REQ-019 Reads of CH[n] SHALL return the channel value zero-extended to 32 bits.
REQ-020 EVENT read data SHALL be: bit31=valid, bits30:28=channel, bits[DATA_W-1:0]=data, all other bits 0.
REQ-021 An EVENT read with the FIFO non-empty SHALL return the head entry with valid=1 and pop it in the same cycle.
REQ-022 An EVENT read with the FIFO empty SHALL return 0 and leave the pointers unchanged.
REQ-023 A push when the FIFO is full SHALL drop the event and set the sticky OVF flag; FIFO contents are unchanged.
REQ-024 Push and pop cannot occur in the same cycle, because REQ-016 makes write and read mutually exclusive.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL range 0..FIFO_DEPTH.
REQ-026 STATUS fields SHALL be: bit0=empty, bit1=full, bit2=OVF, bits[14:8]=count, all other bits 0.
REQ-027 CONTROL fields SHALL be:
- bit0=IE, read/write.
- bit1=CLR_ALL: write 1 zeroes every channel in one cycle, pushes no events, pulses no strobes; self-clearing, reads 0.
- bit2=OVF_CLR: write 1 clears OVF; reads 0.
- bit3=FLUSH: write 1 empties the FIFO; self-clearing, reads 0.
REQ-028 If an overflow push and OVF_CLR coincide, set SHALL win.
REQ-029 irq SHALL equal IE & (~empty | OVF), registered (asserts one cycle after the condition).
REQ-030 readdata SHALL be registered, valid the cycle after the read, and hold its value until the next read.

Reset
REQ-031 On reset assertion, asynchronously and regardless of any in-flight access:
- all channels, out_port, ch_strobe, readdata, irq, IE and OVF go to 0;
- the FIFO empties (pointers=0, count=0).
REQ-032 The first access after reset deassertion SHALL behave normally with no extra wait cycle.

Verification
REQ-033 Write CH[1]=0x001C, then read EVENT -> ch_strobe[1] pulses one cycle; EVENT reads 0x9000001C; STATUS reads 0x00000001.
REQ-034 Write CH[0]=0x0004 twice -> exactly one event queued; STATUS count=1; ch_strobe[0] pulses twice.
REQ-035 With FIFO_DEPTH=8, perform 9 distinct writes -> STATUS=0x00000806 (count 8, full, OVF); 8 EVENT pops return writes 1..8 in order; 9th pop returns 0.
REQ-036 IE=1, one event queued -> irq=1; pop it -> irq=0 one cycle later; force an overflow -> irq=1 until OVF_CLR is written.
REQ-037 CH[2]=0x00FF, then write CONTROL=0x2 -> out_port=0; no strobe; FIFO count unchanged.
REQ-038 Assert reset mid-sequence with 3 events queued -> all outputs 0 and STATUS=0x00000001 immediately after reset.
